// File: rtl/rca_pkg.sv
// Shared definitions for the RCA_16bit accumulator slice.
package rca_pkg;

  localparam int WIDTH             = 16;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int CCNT_W_DEF        = 8;
  localparam int SETTLE_CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/RCA_16bit.sv
// Combinational 16-bit ripple-carry adder built from a chain of full adders.
module RCA_16bit
  import rca_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[WIDTH];

endmodule

// File: rtl/rca16_seq_accumulator.sv
// Multi-operand accumulator feeding RCA_16bit: accumulator on A, operand on B,
// operand carry on cin. Each beat is held on the adder for SETTLE_CYCLES before
// the sum is committed; carry-outs are counted with saturation.
//
// state  | meaning
// IDLE   | ready for the next operand beat
// SETTLE | adder inputs held from registers, counting down to the commit cycle
// DONE   | group result presented, waiting for out_ready
module rca16_seq_accumulator
  import rca_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CCNT_W        = CCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_cin,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [CCNT_W-1:0] out_carries,
  output logic              out_ovf
);

  localparam logic [SETTLE_CNT_W-1:0] CNT_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CCNT_W-1:0]       CCNT_MAX = {CCNT_W{1'b1}};
  localparam logic [CCNT_W-1:0]       CCNT_ONE = CCNT_W'(1);

  state_e                  state_q;
  logic [WIDTH-1:0]        acc_q;
  logic [WIDTH-1:0]        op_b_q;
  logic                    op_cin_q;
  logic                    op_last_q;
  logic [SETTLE_CNT_W-1:0] cnt_q;
  logic [CCNT_W-1:0]       carries_q;
  logic                    ovf_q;

  logic [WIDTH-1:0]        rca_sum;
  logic                    rca_cout;

  // Adder sees only registered values so the ripple chain is stable for the whole settle window.
  RCA_16bit u_rca (
    .a_i    (acc_q),
    .b_i    (op_b_q),
    .cin_i  (op_cin_q),
    .sum_o  (rca_sum),
    .cout_o (rca_cout)
  );

  // Sequencer: beat acceptance, settle countdown, commit, and result handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      op_b_q    <= '0;
      op_cin_q  <= 1'b0;
      op_last_q <= 1'b0;
      cnt_q     <= '0;
      carries_q <= '0;
      ovf_q     <= 1'b0;
    end else if (clr) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      op_b_q    <= '0;
      op_cin_q  <= 1'b0;
      op_last_q <= 1'b0;
      cnt_q     <= '0;
      carries_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_b_q    <= in_data;
            op_cin_q  <= in_cin;
            op_last_q <= in_last;
            cnt_q     <= CNT_LOAD;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - SETTLE_CNT_W'(1);
          end else begin
            acc_q <= rca_sum;
            if (rca_cout) begin
              if (carries_q == CCNT_MAX) begin
                ovf_q <= 1'b1;
              end else begin
                carries_q <= carries_q + CCNT_ONE;
              end
            end
            state_q <= op_last_q ? DONE : IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc_q     <= '0;
            carries_q <= '0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register; data outputs are the registers.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_sum     = acc_q;
  assign out_carries = carries_q;
  assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_rca16_seq_accumulator.sv
// Self-checking bench for rca16_seq_accumulator against an arithmetic group-total model.
module tb_rca16_seq_accumulator;

  localparam int S  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_data = '0;
  logic          in_cin = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_sum;
  logic [CW-1:0] out_carries;
  logic          out_ovf;

  int     checks = 0;
  int     failures = 0;
  longint tot = 0;

  rca16_seq_accumulator #(.SETTLE_CYCLES(S), .CCNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_cin      (in_cin),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .out_ovf     (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Group model: exact integer total of operands plus carries-in.
  function automatic logic [31:0] m_sum();
    longint t;
    t = tot & 64'hFFFF;
    return 32'(t);
  endfunction

  function automatic logic [31:0] m_car();
    longint c;
    c = tot >> 16;
    return (c > 255) ? 32'd255 : 32'(c);
  endfunction

  function automatic logic [31:0] m_ovf();
    return ((tot >> 16) > 255) ? 32'd1 : 32'd0;
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic c, input logic l, input logic hold);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    in_last  = l;
    @(posedge clk);
    @(negedge clk);
    in_valid = hold;
    in_data  = 16'h7777;
    in_cin   = 1'b1;
    in_last  = 1'b0;
    tot += longint'(d) + longint'(c);
    n = 1;
    if (l) begin
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      in_valid = 1'b0;
      check("done_latency", 32'(n), 32'(S + 1));
    end else begin
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      in_valid = 1'b0;
      check("beat_gap", 32'(n), 32'(S + 1));
      check("acc_sum", 32'(out_sum), m_sum());
      check("acc_carries", 32'(out_carries), m_car());
    end
  endtask

  task automatic collect(input int bp);
    logic [15:0] held;
    held = out_sum;
    for (int i = 0; i < bp; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum_stable", 32'(out_sum), 32'(held));
      @(negedge clk);
    end
    check("res_valid", 32'(out_valid), 32'd1);
    check("res_sum", 32'(out_sum), m_sum());
    check("res_carries", 32'(out_carries), m_car());
    check("res_ovf", 32'(out_ovf), m_ovf());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_clear", {15'd0, out_ovf, out_carries, out_sum}, 32'd0);
    tot = 0;
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outs", {14'd0, out_valid, out_ovf, out_carries, out_sum}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset while a beat is settling.
    send_beat(16'h1111, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h00FF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_settle_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_outs", {14'd0, out_valid, out_ovf, out_carries, out_sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tot = 0;
    @(negedge clk);
    send_beat(16'h0001, 1'b0, 1'b1, 1'b0);
    check("after_rst_sum", 32'(out_sum), 32'h0001);
    collect(0);

    // Single beat with carry-in.
    send_beat(16'h1234, 1'b1, 1'b1, 1'b0);
    check("single_sum", 32'(out_sum), 32'h1235);
    collect(0);

    // Wrap with carry, then backpressure with in_valid held (must be ignored).
    send_beat(16'hFFFF, 1'b0, 1'b0, 1'b0);
    check("wrap_acc0", 32'(out_sum), 32'hFFFF);
    send_beat(16'h0001, 1'b0, 1'b0, 1'b1);
    check("wrap_acc1", 32'(out_sum), 32'h0000);
    check("wrap_carry", 32'(out_carries), 32'd1);
    send_beat(16'h8000, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    collect(5);
    in_valid = 1'b0;
    check("wrap_final_sum_model", m_sum(), 32'h0);

    // Saturation of the carry counter.
    for (int i = 0; i < 257; i++) send_beat(16'hFFFF, 1'b0, (i == 256), 1'b0);
    check("sat_sum", 32'(out_sum), 32'hFEFF);
    check("sat_carries", 32'(out_carries), 32'd255);
    check("sat_ovf", 32'(out_ovf), 32'd1);
    collect(0);
    send_beat(16'h0002, 1'b0, 1'b1, 1'b0);
    check("next_group_ovf", 32'(out_ovf), 32'd0);
    collect(1);

    // Synchronous clear during the second beat's settle window.
    send_beat(16'h0100, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0200;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tot = 0;
    check("clr_in_ready", 32'(in_ready), 32'd1);
    check("clr_sum", 32'(out_sum), 32'd0);
    send_beat(16'h0005, 1'b0, 1'b0, 1'b0);
    send_beat(16'h0003, 1'b0, 1'b1, 1'b0);
    check("clr_group_sum", 32'(out_sum), 32'h0008);
    check("clr_group_car", 32'(out_carries), 32'd0);
    collect(0);

    // Randomized groups.
    for (int g = 0; g < 25; g++) begin
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        send_beat(16'($urandom), 1'($urandom_range(0, 1)), (b == nb - 1), 1'($urandom_range(0, 1)));
      end
      collect($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
